// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH iterations; stalls the pipeline while busy.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic               annul_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               stall_o,
   output logic               ready_o,
   output logic [2*WIDTH-1:0] result_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   dvd_q, dvs_q, rem_q;
   logic               sgn_q_q, sgn_r_q;
   logic [2*WIDTH-1:0] result_q, prev_q;

   logic [WIDTH:0]     rem_sh, diff;
   logic               geq, accept, last_iter;
   logic [WIDTH-1:0]   rem_d, dvd_d;
   logic [2*WIDTH-1:0] fin_d;

   function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
      return en ? -v : v;
   endfunction

   always_comb begin
      rem_sh    = {rem_q, dvd_q[WIDTH-1]};
      diff      = rem_sh - {1'b0, dvs_q};
      // a borrow out of the compare-subtract means the shifted remainder was below the divisor
      geq       = ~diff[WIDTH];
      rem_d     = geq ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      dvd_d     = {dvd_q[WIDTH-2:0], geq};
      fin_d     = {neg_if(sgn_r_q, rem_d), neg_if(sgn_q_q, dvd_d)};
      accept    = (state_q == S_IDLE) && start_i && !annul_i;
      last_iter = (cnt_q == CW'(WIDTH - 1));
   end

   assign stall_o  = accept || (state_q == S_DIV);
   assign ready_o  = (state_q == S_DONE) && !annul_i;
   assign result_o = result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         prev_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  cnt_q <= '0;
                  if (b_i == '0) begin
                     prev_q   <= result_q;
                     result_q <= {a_i, {WIDTH{1'b1}}};
                     state_q  <= S_DONE;
                  end else begin
                     dvd_q   <= neg_if(signed_i & a_i[WIDTH-1], a_i);
                     dvs_q   <= neg_if(signed_i & b_i[WIDTH-1], b_i);
                     sgn_q_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                     sgn_r_q <= signed_i & a_i[WIDTH-1];
                     rem_q   <= '0;
                     state_q <= S_DIV;
                  end
               end
            end
            S_DIV: begin
               if (annul_i) begin
                  state_q <= S_IDLE;
               end else begin
                  rem_q <= rem_d;
                  dvd_q <= dvd_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (last_iter) begin
                     prev_q   <= result_q;
                     result_q <= fin_d;
                     state_q  <= S_DONE;
                  end
               end
            end
            default: begin
               // an annulled completion must leave the previously visible result in place
               if (annul_i) result_q <= prev_q;
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against an arithmetic reference model.
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst, start_i, signed_i, annul_i;
   logic [31:0] a_i, b_i;
   logic        stall_o, ready_o;
   logic [63:0] result_o;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
      .a_i(a_i), .b_i(b_i), .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: 0 idle, 1 dividing (m_left edges remain), 2 result cycle
   int          m_phase = 0;
   int          m_left = 0;
   logic [63:0] m_pend = '0, m_res = '0, m_prev = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_res   = '0;
         m_prev  = '0;
      end else begin
         case (m_phase)
            0: if (start_i && !annul_i) begin
               m_pend = ref_div(a_i, b_i, signed_i);
               if (b_i == 32'd0) begin
                  m_prev = m_res; m_res = m_pend; m_phase = 2;
               end else begin
                  m_left = 32; m_phase = 1;
               end
            end
            1: if (annul_i) m_phase = 0;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_prev = m_res; m_res = m_pend; m_phase = 2;
                  end
               end
            default: begin
               if (annul_i) m_res = m_prev;
               m_phase = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {63'd0, stall_o}, {63'd0, (m_phase == 0 && start_i && !annul_i) || m_phase == 1});
         chk("ready", {63'd0, ready_o}, {63'd0, m_phase == 2 && !annul_i});
         chk("result", result_o, m_res);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a divide in the current cycle and waits for ready_o; junk_at injects an ignored start.
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_lat, input int junk_at);
      int cyc = 0;
      bit got = 0;
      start_i = 1'b1; a_i = a; b_i = b; signed_i = s;
      while (cyc < 60) begin
         @(negedge clk);
         if (ready_o) begin got = 1; break; end
         tick();
         cyc++;
         start_i = (cyc == junk_at);
         if (cyc == junk_at) begin a_i = 32'd5; b_i = 32'd1; signed_i = ~s; end
      end
      if (!got) begin
         failures++; checks++;
         $display("FAIL %s_timeout actual=no_ready required=ready_by_cycle_%0d", name, exp_lat);
      end else begin
         chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
         chk({name, "_res"}, result_o, exp);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; a_i = '0; b_i = '0;
      tick();
      chk_en = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_stall", {63'd0, stall_o}, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_result", result_o, 64'd0);
      tick();
      rst = 1'b0;

      chk("model_divu", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
      chk("model_div_neg", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
      chk("model_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h00000000_80000000);

      tick();
      run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, -1);
      run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, -1);
      run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, -1);
      run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33, -1);
      run_div("divu_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 33, -1);
      run_div("dbz", 32'h1234, 32'd0, 1'b1, 64'h00001234_FFFFFFFF, 1, -1);
      run_div("junk_ign", 32'd1000, 32'd9, 1'b0, 64'h00000001_0000006F, 33, 5);

      // annul mid-divide, then a fresh divide starting two cycles later
      start_i = 1'b1; a_i = 32'd999; b_i = 32'd4; signed_i = 1'b0;
      tick();
      start_i = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      @(negedge clk);
      chk("annul_idle_stall", {63'd0, stall_o}, 64'd0);
      chk("annul_keep_res", result_o, 64'h00000001_0000006F);
      tick();
      run_div("after_annul", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, -1);

      // reset in the middle of a divide
      start_i = 1'b1; a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0;
      tick();
      start_i = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_stall", {63'd0, stall_o}, 64'd0);
      chk("midrst_ready", {63'd0, ready_o}, 64'd0);
      chk("midrst_result", result_o, 64'd0);
      tick();

      // randomized traffic with stray starts and occasional annuls while busy
      for (int n = 0; n < 150; n++) begin
         logic [31:0] ra, rb;
         int sel, guard;
         ra = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 15));
            3: begin ra = 32'h8000_0000; rb = $urandom; end
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         start_i = 1'b1; a_i = ra; b_i = rb; signed_i = 1'($urandom);
         tick();
         guard = 0;
         while (m_phase != 0 && guard < 50) begin
            start_i = ($urandom_range(0, 3) == 0);
            a_i = $urandom; b_i = $urandom;
            annul_i = ($urandom_range(0, 63) == 0);
            tick();
            guard++;
         end
         start_i = 1'b0; annul_i = 1'b0;
         if (guard >= 50) begin
            failures++; checks++;
            $display("FAIL rand_timeout actual=busy required=idle_within_50");
         end
         for (int g = 0; g < $urandom_range(0, 2); g++) tick();
      end

      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
